// File: rtl/cdb_arbiter_if.sv
// Bus between the functional units and the CDB arbiter: result handshakes
// going in, the registered broadcast and the slot-occupancy view coming out.
interface cdb_arbiter_if #(
  parameter int NUM_FU = 4,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5
);
  logic [NUM_FU-1:0]       fu_valid;
  logic [NUM_FU*TAG_W-1:0] fu_tag;
  logic [NUM_FU*XLEN-1:0]  fu_value;
  logic [NUM_FU-1:0]       fu_ready;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [XLEN-1:0]         cdb_value;
  logic [NUM_FU-1:0]       pending;

  // Functional-unit / consumer side
  modport master (
    output fu_valid, fu_tag, fu_value,
    input  fu_ready, cdb_valid, cdb_tag, cdb_value, pending
  );

  // Arbiter side
  modport slave (
    input  fu_valid, fu_tag, fu_value,
    output fu_ready, cdb_valid, cdb_tag, cdb_value, pending
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one holding slot per functional unit, a single
// round-robin grant per cycle and a registered broadcast of the granted slot.
// Squash flushes every pending result; reset does the same asynchronously.
module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int XLEN   = 32,
  parameter int TAG_W  = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          squash_i,
  cdb_arbiter_if.slave  bus
);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [NUM_FU-1:0] slot_valid_q;
  logic [TAG_W-1:0]  slot_tag_q   [NUM_FU];
  logic [XLEN-1:0]   slot_value_q [NUM_FU];

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [XLEN-1:0]   cdb_value_q, cdb_value_d;

  logic [NUM_FU-1:0] grant;
  logic              grant_any;
  logic [PTR_W-1:0]  grant_idx;
  logic [NUM_FU-1:0] ready;
  logic [NUM_FU-1:0] capture;

  // Round-robin search: first valid slot at ptr, ptr+1, ... (mod NUM_FU); none while squashing
  always_comb begin
    int idx;
    logic [PTR_W-1:0] idx_w;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    idx_w     = '0;
    if (!squash_i) begin
      for (int k = 0; k < NUM_FU; k++) begin
        idx   = (int'(ptr_q) + k) % NUM_FU;
        idx_w = PTR_W'(idx);
        if (!grant_any && slot_valid_q[idx_w]) begin
          grant_any = 1'b1;
          grant_idx = idx_w;
        end
      end
    end
    if (grant_any) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Next pointer and next broadcast; squash forces everything back to idle
  always_comb begin
    ptr_d       = ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = '0;
    cdb_value_d = '0;
    if (squash_i) begin
      ptr_d = '0;
    end else if (grant_any) begin
      ptr_d       = (int'(grant_idx) == NUM_FU - 1) ? '0 : grant_idx + PTR_W'(1);
      cdb_valid_d = 1'b1;
      cdb_tag_d   = slot_tag_q[grant_idx];
      cdb_value_d = slot_value_q[grant_idx];
    end
  end

  // A slot can take a result when empty or when it is being drained this cycle
  always_comb begin
    ready   = '0;
    capture = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      ready[i]   = !squash_i && (!slot_valid_q[i] || grant[i]);
      capture[i] = bus.fu_valid[i] && ready[i];
    end
  end

  assign bus.fu_ready  = ready;
  assign bus.pending   = slot_valid_q;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_value = cdb_value_q;

  generate
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_slot
      // Holding slot: capture wins over drain so a granted slot can refill in place
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          slot_valid_q[gi] <= 1'b0;
          slot_tag_q[gi]   <= '0;
          slot_value_q[gi] <= '0;
        end else if (squash_i) begin
          slot_valid_q[gi] <= 1'b0;
        end else if (capture[gi]) begin
          slot_valid_q[gi] <= 1'b1;
          slot_tag_q[gi]   <= bus.fu_tag[gi*TAG_W +: TAG_W];
          slot_value_q[gi] <= bus.fu_value[gi*XLEN +: XLEN];
        end else if (grant[gi]) begin
          slot_valid_q[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // Priority pointer and registered CDB broadcast
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by random
// traffic, squash and mid-cycle resets, compared against a slot-level model.
module tb_cdb_arbiter;
  localparam int NUM_FU = 4;
  localparam int XLEN   = 32;
  localparam int TAG_W  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic squash = 1'b0;

  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_FU(NUM_FU), .XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  cdb_arbiter #(.NUM_FU(NUM_FU), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .squash_i (squash),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // FU drivers: each holds its result stable until it is accepted
  bit              drv_valid [NUM_FU];
  logic [TAG_W-1:0] drv_tag  [NUM_FU];
  logic [XLEN-1:0]  drv_value[NUM_FU];
  int               drv_wait [NUM_FU];

  // Reference model state (what the arbiter holds after the last edge)
  bit               m_sv   [NUM_FU];
  logic [TAG_W-1:0] m_st   [NUM_FU];
  logic [XLEN-1:0]  m_sval [NUM_FU];
  int               m_ptr;
  bit               m_cv;
  logic [TAG_W-1:0] m_ct;
  logic [XLEN-1:0]  m_cval;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_FU; i++) m_sv[i] = 0;
    m_ptr = 0; m_cv = 0; m_ct = '0; m_cval = '0;
  endtask

  function automatic logic [NUM_FU-1:0] model_pending();
    logic [NUM_FU-1:0] p;
    for (int i = 0; i < NUM_FU; i++) p[i] = m_sv[i];
    return p;
  endfunction

  // Winner of this cycle: first pending slot walking forward from the pointer
  function automatic int model_winner();
    if (squash) return -1;
    for (int k = 0; k < NUM_FU; k++)
      if (m_sv[(m_ptr + k) % NUM_FU]) return (m_ptr + k) % NUM_FU;
    return -1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NUM_FU; i++) begin
      bus.fu_valid[i]                 = drv_valid[i];
      bus.fu_tag[i*TAG_W +: TAG_W]    = drv_tag[i];
      bus.fu_value[i*XLEN +: XLEN]    = drv_value[i];
    end
  endtask

  task automatic set_req(input int i, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
    drv_valid[i] = 1; drv_tag[i] = t; drv_value[i] = v;
  endtask

  // One clock cycle: check registered outputs, apply stimulus, check ready, advance model
  task automatic run_cycle(input bit sq, input bit do_rst);
    int g;
    bit acc [NUM_FU];
    logic [NUM_FU-1:0] exp_rdy;
    @(negedge clk);
    chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_cv));
    chk("cdb_tag",   64'(bus.cdb_tag),   64'(m_ct));
    chk("cdb_value", 64'(bus.cdb_value), 64'(m_cval));
    chk("pending",   64'(bus.pending),   64'(model_pending()));
    if (m_cv) $display("bcast tag=%0d value=%08h", m_ct, m_cval);
    squash = sq;
    drive_inputs();
    #1;
    g = model_winner();
    for (int i = 0; i < NUM_FU; i++) exp_rdy[i] = !sq && (!m_sv[i] || g == i);
    chk("fu_ready", 64'(bus.fu_ready), 64'(exp_rdy));
    for (int i = 0; i < NUM_FU; i++) acc[i] = drv_valid[i] && exp_rdy[i];
    if (do_rst) begin
      #2 rst = 1'b1;
      #1;
      model_clear();
      for (int i = 0; i < NUM_FU; i++) acc[i] = 0;
      chk("rst_pending",   64'(bus.pending),   64'(0));
      chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'(0));
      chk("rst_fu_ready",  64'(bus.fu_ready),  sq ? 64'(0) : 64'({NUM_FU{1'b1}}));
    end
    @(posedge clk);
    if (!do_rst) begin
      if (sq) begin
        model_clear();
      end else begin
        if (g >= 0) begin
          m_cv = 1; m_ct = m_st[g]; m_cval = m_sval[g];
          m_sv[g] = 0; m_ptr = (g + 1) % NUM_FU;
        end else begin
          m_cv = 0; m_ct = '0; m_cval = '0;
        end
        for (int i = 0; i < NUM_FU; i++)
          if (acc[i]) begin m_sv[i] = 1; m_st[i] = drv_tag[i]; m_sval[i] = drv_value[i]; end
      end
    end
    for (int i = 0; i < NUM_FU; i++) begin
      if (acc[i]) begin
        chk("fair_wait", 64'(drv_wait[i] > NUM_FU), 64'(0));
        drv_valid[i] = 0;
        drv_wait[i]  = 0;
      end else if (drv_valid[i] && !sq && !do_rst) begin
        drv_wait[i]++;
      end else begin
        drv_wait[i] = 0;
      end
    end
    if (do_rst) #2 rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NUM_FU; i++) begin
      drv_valid[i] = 0; drv_tag[i] = '0; drv_value[i] = '0; drv_wait[i] = 0;
    end
    model_clear();
    drive_inputs();
    // Reset state while reset is held
    #2;
    chk("reset_pending",   64'(bus.pending),   64'(0));
    chk("reset_cdb_valid", 64'(bus.cdb_valid), 64'(0));
    chk("reset_cdb_tag",   64'(bus.cdb_tag),   64'(0));
    chk("reset_fu_ready",  64'(bus.fu_ready),  64'({NUM_FU{1'b1}}));
    #1 rst = 1'b0;

    // Single result on FU1
    set_req(1, 5'd7, 32'h0000_DEAD);
    repeat (4) run_cycle(0, 0);

    // Return pointer to 0, then four-way contention with tags 1..4
    run_cycle(1, 0);
    for (int i = 0; i < NUM_FU; i++) set_req(i, TAG_W'(i + 1), 32'h100 + 32'(i));
    repeat (7) run_cycle(0, 0);

    // Two continuous requesters must alternate
    for (int c = 0; c < 12; c++) begin
      if (!drv_valid[0]) set_req(0, TAG_W'($urandom), $urandom);
      if (!drv_valid[2]) set_req(2, TAG_W'($urandom), $urandom);
      run_cycle(0, 0);
    end
    repeat (3) run_cycle(0, 0);

    // Sole requester streaming every cycle
    for (int c = 0; c < 10; c++) begin
      if (!drv_valid[3]) set_req(3, TAG_W'(c), 32'hA000 + 32'(c));
      run_cycle(0, 0);
    end
    repeat (3) run_cycle(0, 0);

    // Squash with slots 0 and 1 pending
    set_req(0, 5'd20, 32'h2020);
    set_req(1, 5'd21, 32'h2121);
    run_cycle(0, 0);
    run_cycle(1, 0);
    repeat (3) run_cycle(0, 0);

    // Asynchronous reset between edges with three slots pending
    set_req(0, 5'd10, 32'h1010);
    set_req(1, 5'd11, 32'h1111);
    set_req(2, 5'd12, 32'h1212);
    run_cycle(0, 0);
    run_cycle(0, 1);
    repeat (5) run_cycle(0, 0);

    // Random traffic with occasional squash and reset
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NUM_FU; i++)
        if (!drv_valid[i] && $urandom_range(0, 2) == 0)
          set_req(i, TAG_W'($urandom), $urandom);
      run_cycle($urandom_range(0, 39) == 0, $urandom_range(0, 149) == 0);
    end
    repeat (NUM_FU + 2) run_cycle(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4, number of functional-unit requesters sharing the CDB.
REQ-002 Parameter XLEN, default 32, result value width.
REQ-003 Parameter TAG_W, default 5, ROB tag width (clog2 of ROB length 32).
REQ-004 clock  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 squash  input  1  branch-mispredict flush; drops all pending results.
REQ-007 fu_valid  input  NUM_FU  FU i presents a completed result.
REQ-008 fu_tag  input  NUM_FU*TAG_W  ROB tag per FU; slice i is bits [i*TAG_W +: TAG_W].
REQ-009 fu_value  input  NUM_FU*XLEN  result value per FU; slice i is bits [i*XLEN +: XLEN].
REQ-010 fu_ready  output  NUM_FU  FU i result is accepted this cycle if fu_valid[i] is high.
REQ-011 cdb_valid  output  1  CDB broadcast valid (registered).
REQ-012 cdb_tag  output  TAG_W  broadcast ROB tag (registered).
REQ-013 cdb_value  output  XLEN  broadcast value (registered).
REQ-014 pending  output  NUM_FU  holding-slot occupancy per FU (registered state, for debug and stall monitoring).

Function
REQ-015 One holding slot per FU: slot_valid, slot_tag, slot_value.
REQ-016 Slot i captures fu_tag/fu_value and sets slot_valid when fu_valid[i] and fu_ready[i] are high at the clock edge.
REQ-017 fu_ready[i] is combinational: !squash and (!slot_valid[i] or grant[i]); a granted slot accepts a new result in the same cycle.
REQ-018 At most one grant per cycle, among slots with slot_valid high; no grant while squash is high.
REQ-019 Round-robin: a priority pointer ptr (clog2(NUM_FU) bits) selects the search start; the grant goes to the first valid slot at index ptr, ptr+1, ... mod NUM_FU.
REQ-020 After a grant to index g, ptr becomes (g+1) mod NUM_FU; ptr is unchanged when no grant occurs.
REQ-021 A granted slot clears slot_valid at the edge unless it is refilled in the same cycle under REQ-017.
REQ-022 At the edge following a grant to g: cdb_valid=1, cdb_tag=slot_tag[g], cdb_value=slot_value[g].
REQ-023 At the edge following a cycle with no grant: cdb_valid=0, cdb_tag=0, cdb_value=0.
REQ-024 Latency from fu_valid to cdb_valid is 2 cycles minimum (capture edge, then grant edge); the worst case under continuous contention is NUM_FU+1 cycles.
REQ-025 An FU holding fu_valid with fu_ready low keeps its tag/value stable; the arbiter does not drop or duplicate results.
REQ-026 squash high at an edge: all slot_valid clear, ptr=0, cdb_valid=0, cdb_tag=0, cdb_value=0; fu_valid inputs in that cycle are ignored.
REQ-027 squash has priority over all captures and grants in the same cycle.
REQ-028 Each accepted result is broadcast exactly once unless it is squashed.

Reset
REQ-029 While reset is high: slot_valid=0, ptr=0, cdb_valid=0, cdb_tag=0, cdb_value=0, pending=0; fu_ready is all-ones if squash is low.
REQ-030 Reset asserted mid-operation discards all pending results immediately, without waiting for a clock edge.
REQ-031 After reset deasserts, the first possible cdb_valid is 2 edges after the first accepted fu_valid.

Verification
REQ-032 Single result: FU1 tag=7 value=0xDEAD at cycle 0 -> cdb_valid=1, tag=7, value=0xDEAD after edge 2 only; pending[1] is 1 for exactly one cycle.
REQ-033 Contention: all 4 FUs valid in cycle 0 (tags 1-4), ptr=0 -> broadcasts tags 1,2,3,4 on consecutive cycles; fu_ready stays low for unserved FUs until each is granted.
REQ-034 Fairness: FU0 and FU2 valid continuously -> grants alternate 0,2,0,2; no FU goes unserved for more than NUM_FU cycles.
REQ-035 Back-to-back refill: FU3 streams a new result every cycle while it is the sole requester -> cdb_valid stays 1 every cycle after the pipeline fills; fu_ready[3] stays 1.
REQ-036 Squash: slots 0 and 1 pending, squash pulses for one cycle -> pending=0, cdb_valid=0 next cycle, ptr=0; neither tag is ever broadcast.
REQ-037 Async reset: reset asserted between edges with 3 slots pending -> pending, cdb_valid, and ptr read 0 before the next rising edge.
